// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction memory
// and buffers {pc, instr} pairs in a first-word-fall-through FIFO toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rd,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_target,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_pc_plus8,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   epc_q   [DEPTH];
    logic          push, pop;

    always_comb begin
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        pop     = dec_valid & dec_ready;
        push    = fetch_en & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);

        // A redirect flushes everything, including a head accepted in the same cycle.
        if (redirect_valid) begin
            pc_d    = redirect_target & ~32'h3;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 32'd4;
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Entries are reset so the head outputs are defined (zero) before the first push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wptr_q] <= imem_rd;
            epc_q[wptr_q]   <= pc_q;
        end
    end

    assign imem_addr    = pc_q;
    assign dec_valid    = (count_q != '0);
    assign dec_instr    = instr_q[rptr_q];
    assign dec_pc       = epc_q[rptr_q];
    assign dec_pc_plus8 = epc_q[rptr_q] + 32'd8;
    assign buf_count    = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based model of the fetch buffer and program counter.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus8;
    logic [$clog2(DEPTH):0] buf_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_pc_plus8    (dec_pc_plus8),
        .buf_count       (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'hE3A0_0005;
            32'h4:   mem_word = 32'hE3A0_1007;
            32'h8:   mem_word = 32'hE080_2001;
            32'hC:   mem_word = 32'hEAFF_FFFE;
            default: mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    always_comb imem_rd = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("imem_addr", imem_addr, mpc);
        check("dec_valid", {31'b0, dec_valid}, {31'b0, mq.size() != 0});
        check("buf_count", 32'(buf_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            check("dec_instr", dec_instr, mq[0].instr);
            check("dec_pc", dec_pc, mq[0].pc);
            check("dec_pc_plus8", dec_pc_plus8, mq[0].pc + 32'd8);
        end
    endtask

    // Model of one clock edge: redirect flushes and wins; otherwise pop the head
    // if decode takes it and append the word at the PC if there is room.
    task automatic model_edge();
        bit do_pop;
        int unsigned sz;
        sz     = mq.size();
        do_pop = (sz != 0) && dec_ready;
        if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_target[31:2], 2'b00};
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (fetch_en && (sz < DEPTH || do_pop)) begin
                mq.push_back('{pc: mpc, instr: mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rt, input logic dr);
        fetch_en        = fe;
        redirect_valid  = rv;
        redirect_target = rt;
        dec_ready       = dr;
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    // Called 1 time unit after a rising edge; reset pulses between edges.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        check("ar_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("ar_buf_count", 32'(buf_count), 32'd0);
        check("ar_imem_addr", imem_addr, RESET_PC);
        mq.delete();
        mpc = RESET_PC;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset           = 1'b0;
        fetch_en        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        dec_ready       = 1'b0;
        mpc             = RESET_PC;
        #1;
        check_state();
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        #1;
        reset = 1'b1;

        // Free-running fetch with decode always ready.
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

        // Decode stalled from reset: buffer fills, PC holds.
        async_reset();
        repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);
        check("full_count", 32'(buf_count), 32'd2);
        check("full_pc", imem_addr, 32'h8);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("pushpop_count", 32'(buf_count), 32'd2);
        check("pushpop_pc", imem_addr, 32'hC);
        repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

        // Redirect with a full buffer and a head being accepted.
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
        check("pre_redir_count", 32'(buf_count), 32'd2);
        cycle(1'b1, 1'b1, 32'h0000_0023, 1'b1);
        check("redir_addr", imem_addr, 32'h20);
        check("redir_count", 32'(buf_count), 32'd0);
        check("redir_valid", {31'b0, dec_valid}, 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("redir_first_pc", dec_pc, 32'h20);
        cycle(1'b1, 1'b0, '0, 1'b1);

        // Redirect while halted, then wrap past the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("halt_redir_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc1", dec_pc, 32'h0000_0000);
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b1);

        // Halted fetch keeps draining; then async reset with one entry buffered.
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("one_entry", 32'(buf_count), 32'd1);
        fetch_en = 1'b0;
        async_reset();
        check_state();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 24) == 0,
                  $urandom(),
                  $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
